// File: rtl/lwc_api_pkg.sv
// Shared constants, state encoding and small helpers for the LWC host-side transmitter.
package lwc_api_pkg;

    localparam logic [3:0] OP_LDKEY  = 4'h4;
    localparam logic [3:0] OP_ACTKEY = 4'h7;
    localparam logic [3:0] OP_ENC    = 4'h2;
    localparam logic [3:0] OP_DEC    = 4'h3;

    localparam logic [3:0] SEG_AD    = 4'h1;
    localparam logic [3:0] SEG_PT    = 4'h4;
    localparam logic [3:0] SEG_CT    = 4'h5;
    localparam logic [3:0] SEG_TAG   = 4'h8;
    localparam logic [3:0] SEG_KEY   = 4'hC;
    localparam logic [3:0] SEG_NPUB  = 4'hD;

    localparam int HDR_TYPE_LSB = 28;
    localparam int HDR_EOI_BIT  = 26;
    localparam int HDR_EOT_BIT  = 25;
    localparam int HDR_LAST_BIT = 24;
    localparam int HDR_LEN_W    = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SDI_INST,
        ST_SDI_HDR,
        ST_SDI_DATA,
        ST_PDI_ACT,
        ST_PDI_INST,
        ST_NPUB_HDR,
        ST_NPUB_DATA,
        ST_AD_HDR,
        ST_AD_DATA,
        ST_MSG_HDR,
        ST_MSG_DATA,
        ST_TAG_HDR,
        ST_TAG_DATA
    } tx_state_t;

    // Byte length rounded up to whole 32-bit words; 0xFFFF bytes still fits in 15 bits.
    function automatic logic [14:0] word_count(input logic [15:0] len_bytes);
        logic [16:0] sum;
        sum = {1'b0, len_bytes} + 17'd3;
        return sum[16:2];
    endfunction

    function automatic logic [31:0] inst_word(input logic [3:0] opcode);
        return {opcode, 28'h0};
    endfunction

endpackage

// File: rtl/lwc_seg_hdr.sv
// Packs segment header fields into the 32-bit LWC API header word.
module lwc_seg_hdr
    import lwc_api_pkg::*;
(
    input  logic [3:0]  seg_type,
    input  logic        eoi,
    input  logic        eot,
    input  logic        last,
    input  logic [15:0] len,
    output logic [31:0] hdr_word
);

    always_comb begin
        hdr_word                        = '0;
        hdr_word[HDR_TYPE_LSB +: 4]     = seg_type;
        hdr_word[HDR_EOI_BIT]           = eoi;
        hdr_word[HDR_EOT_BIT]           = eot;
        hdr_word[HDR_LAST_BIT]          = last;
        hdr_word[HDR_LEN_W-1:0]         = len;
    end

endmodule

// File: rtl/lwc_host_tx.sv
// Host-side LWC API transmitter: sequences instructions and headers, splicing key/din words
// straight through to the core's sdi/pdi ports.
module lwc_host_tx
    import lwc_api_pkg::*;
#(
    parameter int NPUB_WORDS = 4,
    parameter int KEY_WORDS  = 4,
    parameter int TAG_WORDS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_decrypt,
    input  logic        cmd_newkey,
    input  logic [15:0] cmd_ad_len,
    input  logic [15:0] cmd_msg_len,
    input  logic [31:0] key_data,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [31:0] din_data,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] pdi_data,
    output logic        pdi_valid,
    input  logic        pdi_ready,
    output logic [31:0] sdi_data,
    output logic        sdi_valid,
    input  logic        sdi_ready,
    output logic        busy
);

    tx_state_t   state;
    logic [14:0] word_cnt;
    logic [14:0] ad_words;
    logic [14:0] msg_words;
    logic [15:0] ad_len_q;
    logic [15:0] msg_len_q;
    logic        decrypt_q;

    logic        pdi_xfer;
    logic        sdi_xfer;
    logic        last_word;
    tx_state_t   after_msg;

    logic [3:0]  hdr_type;
    logic        hdr_eoi;
    logic        hdr_last;
    logic [15:0] hdr_len;
    logic [31:0] hdr_word;

    assign pdi_xfer  = pdi_valid && pdi_ready;
    assign sdi_xfer  = sdi_valid && sdi_ready;
    assign last_word = (word_cnt == 15'd1);
    assign after_msg = decrypt_q ? ST_TAG_HDR : ST_IDLE;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Each state advances on its final transfer; zero-length AD/MSG skip their data state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            ad_words  <= '0;
            msg_words <= '0;
            ad_len_q  <= '0;
            msg_len_q <= '0;
            decrypt_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        decrypt_q <= cmd_decrypt;
                        ad_len_q  <= cmd_ad_len;
                        msg_len_q <= cmd_msg_len;
                        ad_words  <= word_count(cmd_ad_len);
                        msg_words <= word_count(cmd_msg_len);
                        state     <= cmd_newkey ? ST_SDI_INST : ST_PDI_INST;
                    end
                end
                ST_SDI_INST: if (sdi_xfer) state <= ST_SDI_HDR;
                ST_SDI_HDR: begin
                    if (sdi_xfer) begin
                        state    <= ST_SDI_DATA;
                        word_cnt <= 15'(KEY_WORDS);
                    end
                end
                ST_SDI_DATA: begin
                    if (sdi_xfer) begin
                        word_cnt <= word_cnt - 15'd1;
                        if (last_word) state <= ST_PDI_ACT;
                    end
                end
                ST_PDI_ACT:  if (pdi_xfer) state <= ST_PDI_INST;
                ST_PDI_INST: if (pdi_xfer) state <= ST_NPUB_HDR;
                ST_NPUB_HDR: begin
                    if (pdi_xfer) begin
                        state    <= ST_NPUB_DATA;
                        word_cnt <= 15'(NPUB_WORDS);
                    end
                end
                ST_NPUB_DATA: begin
                    if (pdi_xfer) begin
                        word_cnt <= word_cnt - 15'd1;
                        if (last_word) state <= ST_AD_HDR;
                    end
                end
                ST_AD_HDR: begin
                    if (pdi_xfer) begin
                        word_cnt <= ad_words;
                        state    <= (ad_words != '0) ? ST_AD_DATA : ST_MSG_HDR;
                    end
                end
                ST_AD_DATA: begin
                    if (pdi_xfer) begin
                        word_cnt <= word_cnt - 15'd1;
                        if (last_word) state <= ST_MSG_HDR;
                    end
                end
                ST_MSG_HDR: begin
                    if (pdi_xfer) begin
                        word_cnt <= msg_words;
                        state    <= (msg_words != '0) ? ST_MSG_DATA : after_msg;
                    end
                end
                ST_MSG_DATA: begin
                    if (pdi_xfer) begin
                        word_cnt <= word_cnt - 15'd1;
                        if (last_word) state <= after_msg;
                    end
                end
                ST_TAG_HDR: begin
                    if (pdi_xfer) begin
                        state    <= ST_TAG_DATA;
                        word_cnt <= 15'(TAG_WORDS);
                    end
                end
                ST_TAG_DATA: begin
                    if (pdi_xfer) begin
                        word_cnt <= word_cnt - 15'd1;
                        if (last_word) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // EOI lands on the last non-empty pdi segment: MSG, else AD, else NPUB.
    always_comb begin
        hdr_type = SEG_NPUB;
        hdr_eoi  = 1'b0;
        hdr_last = 1'b0;
        hdr_len  = '0;
        case (state)
            ST_SDI_HDR: begin
                hdr_type = SEG_KEY;
                hdr_eoi  = 1'b1;
                hdr_last = 1'b1;
                hdr_len  = 16'(4 * KEY_WORDS);
            end
            ST_NPUB_HDR: begin
                hdr_type = SEG_NPUB;
                hdr_eoi  = (ad_len_q == '0) && (msg_len_q == '0);
                hdr_len  = 16'(4 * NPUB_WORDS);
            end
            ST_AD_HDR: begin
                hdr_type = SEG_AD;
                hdr_eoi  = (ad_len_q != '0) && (msg_len_q == '0);
                hdr_len  = ad_len_q;
            end
            ST_MSG_HDR: begin
                hdr_type = decrypt_q ? SEG_CT : SEG_PT;
                hdr_eoi  = (msg_len_q != '0);
                hdr_last = !decrypt_q;
                hdr_len  = msg_len_q;
            end
            ST_TAG_HDR: begin
                hdr_type = SEG_TAG;
                hdr_last = 1'b1;
                hdr_len  = 16'(4 * TAG_WORDS);
            end
            default: ;
        endcase
    end

    lwc_seg_hdr u_seg_hdr (
        .seg_type (hdr_type),
        .eoi      (hdr_eoi),
        .eot      (1'b1),
        .last     (hdr_last),
        .len      (hdr_len),
        .hdr_word (hdr_word)
    );

    // Header/instruction states hold a state-derived word; data states are wired straight through.
    always_comb begin
        pdi_valid = 1'b0;
        pdi_data  = '0;
        sdi_valid = 1'b0;
        sdi_data  = '0;
        din_ready = 1'b0;
        key_ready = 1'b0;
        case (state)
            ST_SDI_INST: begin
                sdi_valid = 1'b1;
                sdi_data  = inst_word(OP_LDKEY);
            end
            ST_SDI_HDR: begin
                sdi_valid = 1'b1;
                sdi_data  = hdr_word;
            end
            ST_SDI_DATA: begin
                sdi_valid = key_valid;
                sdi_data  = key_data;
                key_ready = sdi_ready;
            end
            ST_PDI_ACT: begin
                pdi_valid = 1'b1;
                pdi_data  = inst_word(OP_ACTKEY);
            end
            ST_PDI_INST: begin
                pdi_valid = 1'b1;
                pdi_data  = inst_word(decrypt_q ? OP_DEC : OP_ENC);
            end
            ST_NPUB_HDR, ST_AD_HDR, ST_MSG_HDR, ST_TAG_HDR: begin
                pdi_valid = 1'b1;
                pdi_data  = hdr_word;
            end
            ST_NPUB_DATA, ST_AD_DATA, ST_MSG_DATA, ST_TAG_DATA: begin
                pdi_valid = din_valid;
                pdi_data  = din_data;
                din_ready = pdi_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lwc_host_tx.sv
// Randomized self-checking bench for lwc_host_tx against a queue-based model of the expected streams.
module tb_lwc_host_tx;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_decrypt;
    logic        cmd_newkey;
    logic [15:0] cmd_ad_len;
    logic [15:0] cmd_msg_len;
    logic [31:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] din_data;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] pdi_data;
    logic        pdi_valid;
    logic        pdi_ready;
    logic [31:0] sdi_data;
    logic        sdi_valid;
    logic        sdi_ready;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] din_q[$];
    logic [31:0] key_q[$];
    logic [31:0] exp_pdi[$];
    logic [31:0] exp_sdi[$];

    lwc_host_tx dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_decrypt (cmd_decrypt),
        .cmd_newkey  (cmd_newkey),
        .cmd_ad_len  (cmd_ad_len),
        .cmd_msg_len (cmd_msg_len),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .din_data    (din_data),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .pdi_data    (pdi_data),
        .pdi_valid   (pdi_valid),
        .pdi_ready   (pdi_ready),
        .sdi_data    (sdi_data),
        .sdi_valid   (sdi_valid),
        .sdi_ready   (sdi_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] hdrWord(input int seg_type, input bit eoi, input bit last, input int len);
        logic [31:0] w;
        w = 32'(len % 65536) + 32'(seg_type) * 32'h1000_0000 + 32'h0200_0000;
        if (eoi)  w = w + 32'h0400_0000;
        if (last) w = w + 32'h0100_0000;
        return w;
    endfunction

    // Expected sdi/pdi transfer streams for one operation, built from din_q/key_q.
    task automatic buildExpected(input bit dec, input bit newkey, input int ad_len, input int msg_len);
        int p;
        int adw;
        int msgw;
        adw  = (ad_len + 3) / 4;
        msgw = (msg_len + 3) / 4;
        p    = 0;
        exp_pdi.delete();
        exp_sdi.delete();
        if (newkey) begin
            exp_sdi.push_back(32'h4000_0000);
            exp_sdi.push_back(hdrWord(12, 1'b1, 1'b1, 16));
            for (int i = 0; i < 4; i++) exp_sdi.push_back(key_q[i]);
            exp_pdi.push_back(32'h7000_0000);
        end
        exp_pdi.push_back(dec ? 32'h3000_0000 : 32'h2000_0000);
        exp_pdi.push_back(hdrWord(13, (ad_len == 0) && (msg_len == 0), 1'b0, 16));
        for (int i = 0; i < 4; i++) exp_pdi.push_back(din_q[p++]);
        exp_pdi.push_back(hdrWord(1, (ad_len != 0) && (msg_len == 0), 1'b0, ad_len));
        for (int i = 0; i < adw; i++) exp_pdi.push_back(din_q[p++]);
        exp_pdi.push_back(hdrWord(dec ? 5 : 4, msg_len != 0, !dec, msg_len));
        for (int i = 0; i < msgw; i++) exp_pdi.push_back(din_q[p++]);
        if (dec) begin
            exp_pdi.push_back(hdrWord(8, 1'b0, 1'b1, 16));
            for (int i = 0; i < 4; i++) exp_pdi.push_back(din_q[p++]);
        end
    endtask

    // One operation: issue the command, then drive random handshakes until busy drops.
    task automatic applyStimulus(input bit dec, input bit newkey, input int ad_len, input int msg_len,
                                 input int low_pct, input bit stall_npub, input int abort_at);
        logic [31:0] got_pdi[$];
        logic [31:0] got_sdi[$];
        logic [31:0] npub_hdr;
        int need, din_idx, key_idx, cycles, stall_left, pass_err, overlap, cmp_len;
        bit started, done, aborted, stalling, din_take, key_take;

        need = 4 + (ad_len + 3) / 4 + (msg_len + 3) / 4 + (dec ? 4 : 0);
        din_q.delete();
        key_q.delete();
        for (int i = 0; i < need + 4; i++) din_q.push_back($urandom);
        for (int i = 0; i < 6; i++) key_q.push_back($urandom);
        buildExpected(dec, newkey, ad_len, msg_len);
        npub_hdr = hdrWord(13, (ad_len == 0) && (msg_len == 0), 1'b0, 16);

        din_idx = 0; key_idx = 0; cycles = 0; pass_err = 0; overlap = 0;
        stall_left = stall_npub ? 3 : 0;
        started = 0; done = 0; aborted = 0; stalling = 0;

        cmd_valid   = 1'b1;
        cmd_decrypt = dec;
        cmd_newkey  = newkey;
        cmd_ad_len  = 16'(ad_len);
        cmd_msg_len = 16'(msg_len);
        din_valid   = 1'b1;
        din_data    = din_q[0];
        key_valid   = 1'b1;
        key_data    = key_q[0];
        pdi_ready   = 1'b1;
        sdi_ready   = 1'b1;

        while (!done) begin
            @(negedge clk);
            if (!started) begin
                checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
                started = 1;
            end else if (!busy) begin
                done = 1;
            end
            if (stalling) begin
                checkOutput("npub_hold_data", pdi_data, npub_hdr);
                checkOutput("npub_hold_valid", 32'(pdi_valid), 32'd1);
                checkOutput("npub_hold_din_ready", 32'(din_ready), 32'd0);
            end
            if (pdi_valid && sdi_valid) overlap++;
            if (din_ready && ((pdi_valid !== din_valid) || (pdi_data !== din_data))) pass_err++;
            if (key_ready && ((sdi_valid !== key_valid) || (sdi_data !== key_data))) pass_err++;
            if (pdi_valid && pdi_ready) got_pdi.push_back(pdi_data);
            if (sdi_valid && sdi_ready) got_sdi.push_back(sdi_data);
            din_take = din_valid && din_ready;
            key_take = key_valid && key_ready;
            if (abort_at >= 0 && got_pdi.size() == abort_at) begin
                aborted = 1;
                done    = 1;
            end
            cycles++;
            if (cycles > 40000) begin
                checkOutput("op_timeout", 32'(busy), 32'd0);
                done = 1;
            end

            @(posedge clk);
            #1;
            if (din_take) din_idx++;
            if (key_take) key_idx++;
            cmd_valid   = busy && ($urandom_range(3) == 0);
            cmd_decrypt = 1'($urandom_range(1));
            cmd_newkey  = 1'($urandom_range(1));
            cmd_ad_len  = 16'($urandom);
            cmd_msg_len = 16'($urandom);
            stalling  = 0;
            pdi_ready = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
            sdi_ready = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
            if (stall_left > 0 && pdi_valid && !din_ready && pdi_data[31:28] == 4'hD) begin
                pdi_ready = 1'b0;
                stall_left--;
                stalling = 1;
            end
            din_valid = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
            din_data  = (din_idx < din_q.size()) ? din_q[din_idx] : $urandom;
            key_valid = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
            key_data  = (key_idx < key_q.size()) ? key_q[key_idx] : $urandom;
        end
        cmd_valid = 1'b0;

        if (aborted) begin
            for (int i = 0; i < got_pdi.size(); i++)
                checkOutput($sformatf("abort_prefix[%0d]", i), got_pdi[i], exp_pdi[i]);
            rst = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("rst_pdi_valid", 32'(pdi_valid), 32'd0);
            checkOutput("rst_sdi_valid", 32'(sdi_valid), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            rst = 1'b0;
        end else begin
            checkOutput("sdi_count", 32'(got_sdi.size()), 32'(exp_sdi.size()));
            checkOutput("pdi_count", 32'(got_pdi.size()), 32'(exp_pdi.size()));
            cmp_len = (got_sdi.size() < exp_sdi.size()) ? got_sdi.size() : exp_sdi.size();
            for (int i = 0; i < cmp_len; i++)
                checkOutput($sformatf("sdi[%0d]", i), got_sdi[i], exp_sdi[i]);
            cmp_len = (got_pdi.size() < exp_pdi.size()) ? got_pdi.size() : exp_pdi.size();
            for (int i = 0; i < cmp_len; i++)
                checkOutput($sformatf("pdi[%0d]", i), got_pdi[i], exp_pdi[i]);
            checkOutput("din_consumed", 32'(din_idx), 32'(need));
            checkOutput("key_consumed", 32'(key_idx), newkey ? 32'd4 : 32'd0);
            checkOutput("pdi_sdi_overlap", 32'(overlap), 32'd0);
            checkOutput("passthrough", 32'(pass_err), 32'd0);
            checkOutput("idle_after_op", 32'(busy), 32'd0);
            if (stall_npub) checkOutput("npub_stall_used", 32'(stall_left), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_decrypt = 1'b0;
        cmd_newkey  = 1'b0;
        cmd_ad_len  = '0;
        cmd_msg_len = '0;
        key_data    = '0;
        key_valid   = 1'b0;
        din_data    = '0;
        din_valid   = 1'b0;
        pdi_ready   = 1'b0;
        sdi_ready   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pdi_valid", 32'(pdi_valid), 32'd0);
        checkOutput("reset_sdi_valid", 32'(sdi_valid), 32'd0);
        checkOutput("reset_key_ready", 32'(key_ready), 32'd0);
        checkOutput("reset_din_ready", 32'(din_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_pdi_data", pdi_data, 32'd0);
        checkOutput("reset_sdi_data", sdi_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_pdi_valid", 32'(pdi_valid), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 5, 8, 0, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 4, 1, 0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 3, 6, 0, 1'b1, -1);
        applyStimulus(1'b1, 1'b1, 13, 9, 50, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 5, 16, 0, 1'b0, 11);
        applyStimulus(1'b0, 1'b1, 7, 3, 0, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 9, 0, 30, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 0, 65535, 0, 1'b0, -1);

        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                          $urandom_range(40), $urandom_range(40),
                          $urandom_range(60), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
